// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory fetch controller.
//   state_e : controller FSM states (StPref only exists with IMEM_PREFETCH_EN)
//   owner_e : which port owns the transaction in flight
// Build option: IMEM_PREFETCH_EN adds the next-word prefetch state.
package imem_pkg;

  localparam int unsigned DefALength = 12;
  localparam int unsigned DefDLength = 8;

`ifdef IMEM_PREFETCH_EN
  typedef enum logic [1:0] {StIdle, StRead, StResp, StPref} state_e;
`else
  typedef enum logic [1:0] {StIdle, StRead, StResp} state_e;
`endif

  typedef enum logic {OwnerFetch, OwnerDebug} owner_e;

endpackage

// File: rtl/imem_rr_arb.sv
// Two-requester round-robin arbiter for the fetch and debug ports.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   req_f_i      : fetch port request
//   req_d_i      : debug port request
//   accept_i     : controller is able to take a grant this cycle
//   gnt_o        : some request is present
//   owner_o      : port being granted
// On a collision the port that was not granted last wins. The pointer resets to
// debug-last so that the first collision after reset goes to fetch.
module imem_rr_arb
  import imem_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   req_f_i,
  input  logic   req_d_i,
  input  logic   accept_i,
  output logic   gnt_o,
  output owner_e owner_o
);

  owner_e last_q, last_d;

  always_comb begin
    gnt_o = req_f_i | req_d_i;
    if (req_f_i && req_d_i) begin
      owner_o = (last_q == OwnerFetch) ? OwnerDebug : OwnerFetch;
    end else if (req_d_i) begin
      owner_o = OwnerDebug;
    end else begin
      owner_o = OwnerFetch;
    end
    last_d = last_q;
    if (accept_i && gnt_o) begin
      last_d = owner_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= OwnerDebug;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory fetch controller: serves 32-bit words to a fetch port and
// a debug/loader port from a combinational byte-wide ROM, four beats per word,
// assembled big-endian (byte at base lands in [31:24]).
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   f_req/f_addr       : fetch request (held until f_valid), address word-aligned
//   f_rdata/f_valid    : fetch word and one-cycle response strobe
//   d_req/d_addr       : debug request (held until d_valid), any alignment
//   d_rdata/d_valid    : debug word and one-cycle response strobe
//   mem_addr/mem_rdata : byte ROM address and same-cycle data
//   busy               : controller not idle
// Build option: IMEM_PREFETCH_EN reads the word after the last fetch into a
// one-word buffer while idle; a fetch hitting it responds the next cycle.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned A_length = DefALength,
  parameter int unsigned D_length = DefDLength
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                f_req,
  input  logic [A_length-1:0] f_addr,
  output logic [31:0]         f_rdata,
  output logic                f_valid,
  input  logic                d_req,
  input  logic [A_length-1:0] d_addr,
  output logic [31:0]         d_rdata,
  output logic                d_valid,
  output logic [A_length-1:0] mem_addr,
  input  logic [D_length-1:0] mem_rdata,
  output logic                busy
);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [1:0]          beat_q, beat_d;
  logic [A_length-1:0] base_q, base_d;
  logic [31:0]         word_q, word_d;
  logic [31:0]         f_rdata_q, f_rdata_d;
  logic [31:0]         d_rdata_q, d_rdata_d;

  logic [31:0]         word_shift;
  logic [A_length-1:0] f_base;
  logic [1:0]          unused_f_addr;
  logic                sample;
  logic                arb_gnt;
  owner_e              arb_owner;

  assign f_base        = {f_addr[A_length-1:2], 2'b00};
  assign unused_f_addr = f_addr[1:0];
  // Each captured byte shifts in at the bottom, so the first byte ends up on top.
  assign word_shift    = (word_q << D_length) | 32'(mem_rdata);

`ifdef IMEM_PREFETCH_EN
  logic                buf_valid_q, buf_valid_d;
  logic [A_length-1:0] buf_addr_q, buf_addr_d;
  logic [31:0]         buf_data_q, buf_data_d;
  logic                pref_pend_q, pref_pend_d;
  logic [A_length-1:0] pref_addr_q, pref_addr_d;
  logic                buf_hit;

  assign buf_hit = buf_valid_q && (buf_addr_q == f_base);
  // A prefetch in progress is abandoned in favour of any real request.
  assign sample  = (state_q == StIdle) || (state_q == StPref);
`else
  assign sample  = (state_q == StIdle);
`endif

  imem_rr_arb u_arb (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_f_i  (f_req),
    .req_d_i  (d_req),
    .accept_i (sample),
    .gnt_o    (arb_gnt),
    .owner_o  (arb_owner)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q     <= OwnerFetch;
      beat_q      <= '0;
      base_q      <= '0;
      word_q      <= '0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
`ifdef IMEM_PREFETCH_EN
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      pref_pend_q <= 1'b0;
      pref_addr_q <= '0;
`endif
    end else begin
      owner_q     <= owner_d;
      beat_q      <= beat_d;
      base_q      <= base_d;
      word_q      <= word_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
`ifdef IMEM_PREFETCH_EN
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      pref_pend_q <= pref_pend_d;
      pref_addr_q <= pref_addr_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    beat_d      = beat_q;
    base_d      = base_q;
    word_d      = word_q;
    f_rdata_d   = f_rdata_q;
    d_rdata_d   = d_rdata_q;
`ifdef IMEM_PREFETCH_EN
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    pref_pend_d = pref_pend_q;
    pref_addr_d = pref_addr_q;
`endif
    if (sample && arb_gnt) begin
      owner_d = arb_owner;
      beat_d  = '0;
      word_d  = '0;
      base_d  = (arb_owner == OwnerFetch) ? f_base : d_addr;
      state_d = StRead;
`ifdef IMEM_PREFETCH_EN
      pref_pend_d = 1'b0;
      if ((arb_owner == OwnerFetch) && buf_hit) begin
        state_d   = StResp;
        f_rdata_d = buf_data_q;
      end
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
`ifdef IMEM_PREFETCH_EN
          if (pref_pend_q) begin
            state_d     = StPref;
            base_d      = pref_addr_q;
            beat_d      = '0;
            word_d      = '0;
            buf_valid_d = 1'b0;
            pref_pend_d = 1'b0;
          end
`endif
        end
        StRead: begin
          word_d = word_shift;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d = StResp;
            if (owner_q == OwnerFetch) begin
              f_rdata_d = word_shift;
            end else begin
              d_rdata_d = word_shift;
            end
          end
        end
        StResp: begin
          state_d = StIdle;
`ifdef IMEM_PREFETCH_EN
          if (owner_q == OwnerFetch) begin
            pref_pend_d = 1'b1;
            pref_addr_d = base_q + A_length'(3'd4);
          end
`endif
        end
`ifdef IMEM_PREFETCH_EN
        StPref: begin
          word_d = word_shift;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            buf_data_d  = word_shift;
            buf_addr_d  = base_q;
            buf_valid_d = 1'b1;
            state_d     = StIdle;
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy     = (state_q != StIdle);
    f_valid  = (state_q == StResp) && (owner_q == OwnerFetch);
    d_valid  = (state_q == StResp) && (owner_q == OwnerDebug);
    mem_addr = '0;
    if (state_q == StRead) begin
      mem_addr = base_q + A_length'(beat_q);
    end
`ifdef IMEM_PREFETCH_EN
    if (state_q == StPref) begin
      mem_addr = base_q + A_length'(beat_q);
    end
`endif
  end

  assign f_rdata = f_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule
